fft_result_reader: RTL and testbench

- Readout stage for the radix-2 FFT engine; the other end of the engine's ping-pong result BRAMs.
- On a start pulse, reads N complex bins ({i,q} packed, i in upper half) from the selected bank via port A, one-cycle read latency.
- Re-orders bins from bit-reversed storage to natural frequency order.
- Streams bins out on a valid/ready interface with index and last flags.

---
 rtl/fft_result_reader.sv | 179 +++++++++++++++++
 tb/tb_fft_result_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// ============================================================================
// Module      : fft_result_reader
// Description : Reads N complex FFT bins from the selected ping-pong result
//               BRAM and streams them out in order on a valid/ready port.
//               FFT_READER_BITREV_EN: read addresses are bit-reversed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_result_reader #(
    parameter int N          = 64,
    parameter int DATA_WIDTH = 8,
    parameter int BRAM_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bank_sel,
    output logic                    ram0_en,
    output logic                    ram1_en,
    output logic [BRAM_WIDTH-1:0]   ram_addr,
    input  logic [2*DATA_WIDTH-1:0] ram0_dout,
    input  logic [2*DATA_WIDTH-1:0] ram1_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_i,
    output logic [DATA_WIDTH-1:0]   out_q,
    output logic [$clog2(N)-1:0]    out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int ADDR_WIDTH = $clog2(N);
    localparam int ENTRY_W    = 2*DATA_WIDTH + ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    bank_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   inflight_idx_q;

    logic [ENTRY_W-1:0]      fifo_mem_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic [1:0]              count_d;

    logic                    w_start_ok;
    logic                    w_pop;
    logic [2:0]              w_occ;
    logic                    w_credit;
    logic                    w_issue;
    logic                    w_bank;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [2*DATA_WIDTH-1:0] w_rdata;
    logic [ENTRY_W-1:0]      w_entry;

`ifdef FFT_READER_BITREV_EN
    for (genvar b = 0; b < ADDR_WIDTH; b++) begin : g_bitrev
        assign w_addr[b] = rd_cnt_q[ADDR_WIDTH-1-b];
    end
`else
    assign w_addr = rd_cnt_q;
`endif

    assign w_start_ok = (state_q == S_IDLE) && start;
    assign out_valid  = (count_q != 2'd0);
    assign w_pop      = out_valid && out_ready;

    // The bin leaving this cycle frees its slot before the new read can land.
    assign w_occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_credit = (w_occ < 3'd2);
    assign w_issue  = !rst && w_credit && (w_start_ok || (state_q == S_READ));

    // The first read goes out in the start cycle, before bank_q is loaded.
    assign w_bank   = (state_q == S_IDLE) ? bank_sel : bank_q;
    assign ram0_en  = w_issue && !w_bank;
    assign ram1_en  = w_issue && w_bank;
    assign ram_addr = w_issue ? BRAM_WIDTH'(w_addr) : '0;

    assign w_rdata = bank_q ? ram1_dout : ram0_dout;
    assign w_entry = {w_rdata, inflight_idx_q,
                      (inflight_idx_q == ADDR_WIDTH'(N-1))};

    assign {out_i, out_q, out_index, out_last} = fifo_mem_q[rd_ptr_q];
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bank_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rd_cnt_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= w_issue;
            if (w_issue) begin
                inflight_idx_q <= rd_cnt_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bank_q   <= bank_sel;
                        busy_q   <= 1'b1;
                        rd_cnt_q <= ADDR_WIDTH'(1);
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        if (rd_cnt_q == ADDR_WIDTH'(N-1)) begin
                            state_q <= S_DRAIN;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && out_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_cnt_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (inflight_q && !w_pop) begin
            count_d = count_q + 2'd1;
        end else if (!inflight_q && w_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                fifo_mem_q[e] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_mem_q[wr_ptr_q] <= w_entry;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_result_reader.sv
// ============================================================================
// Module      : tb_fft_result_reader
// Description : Scoreboard bench for fft_result_reader, N=8, with BRAM models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_result_reader;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int BW = 10;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bank_sel;
    logic          ram0_en;
    logic          ram1_en;
    logic [BW-1:0] ram_addr;
    logic [15:0]   ram0_dout = '0;
    logic [15:0]   ram1_dout = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    fft_result_reader #(.N(N), .DATA_WIDTH(DW), .BRAM_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
        .ram0_en(ram0_en), .ram1_en(ram1_en), .ram_addr(ram_addr),
        .ram0_dout(ram0_dout), .ram1_dout(ram1_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_index(out_index),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem0 [N];
    logic [15:0] mem1 [N];

    always @(posedge clk) begin
        if (ram0_en) ram0_dout <= mem0[ram_addr[AW-1:0]];
        if (ram1_en) ram1_dout <= mem1[ram_addr[AW-1:0]];
    end

    typedef struct packed {
        logic [7:0]    i;
        logic [7:0]    q;
        logic [AW-1:0] idx;
        logic          last;
    } bin_t;

    bin_t          exp_q [$];
    logic [BW-1:0] addr_q [$];
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic          exp_bank  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [BW-1:0] exp_addr(input int k);
        logic [AW-1:0] a;
        logic [AW-1:0] r;
        a = AW'(k);
`ifdef FFT_READER_BITREV_EN
        for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
`else
        r = a;
`endif
        return BW'(r);
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return (c % 4 == 0) || (c % 4 == 3);
    endfunction

    // Monitor: address/bank/credit on every read, scoreboard on every transfer.
    int   issued   = 0;
    int   accepted = 0;
    logic stall_prev = 1'b0;
    bin_t stall_val;
    bin_t mon_cur;
    logic mon_hs;

    always @(negedge clk) begin
        if (rst) begin
            issued     = 0;
            accepted   = 0;
            stall_prev = 1'b0;
        end else begin
            mon_cur = '{i: out_i, q: out_q, idx: out_index, last: out_last};
            mon_hs  = out_valid && out_ready;
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(mon_cur), 32'(stall_val));
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = mon_cur;
            if (ram0_en || ram1_en) begin
                check("credit", 32'((issued - accepted - (mon_hs ? 1 : 0)) < 2), 1);
                check("en_bank", 32'({ram1_en, ram0_en}), exp_bank ? 2 : 1);
                check("read_expected", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) check("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
                issued++;
            end
            if (mon_hs) begin
                accepted++;
                check("bin_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("bin", 32'(mon_cur), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_readout(input logic bank, input int mode, input bit restart,
                               input bit do_rst, input bit toggle);
        int          done_c;
        int          done_n;
        logic [15:0] d;
        bin_t        b;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            d      = bank ? mem1[exp_addr(k)] : mem0[exp_addr(k)];
            b.i    = d[15:8];
            b.q    = d[7:0];
            b.idx  = AW'(k);
            b.last = (k == N-1);
            exp_q.push_back(b);
            addr_q.push_back(exp_addr(k));
        end
        exp_bank  = bank;
        start     = 1'b1;
        bank_sel  = bank;
        out_ready = ready_for(mode, 0);
        @(negedge clk);
        check("busy_before", 32'(busy), 0);
        @(posedge clk); #1;
        start  = 1'b0;
        done_c = -1;
        done_n = 0;
        for (int c = 1; c <= 200; c++) begin
            start     = restart && (c == 3 || c == N+2);
            out_ready = ready_for(mode, c);
            if (toggle && c == 4) bank_sel = ~bank;
            if (do_rst && c == 6) rst = 1'b1;
            if (do_rst && c == 7) rst = 1'b0;
            @(negedge clk);
            if (c == 1) check("busy_start", 32'(busy), 1);
            if (mode == 0 && c == 1) check("valid_lat1", 32'(out_valid), 0);
            if (mode == 0 && c == 2) check("valid_lat2", 32'(out_valid), 1);
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (do_rst && c == 6) check("pre_rst_bin4", 32'({out_valid, out_index}), 32'({1'b1, 3'd4}));
            if (do_rst && c == 7) begin
                check("rst_valid", 32'(out_valid), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_en", 32'({ram0_en, ram1_en}), 0);
                check("rst_done", 32'(done), 0);
                exp_q.delete();
                addr_q.delete();
                break;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            @(posedge clk); #1;
        end
        if (!do_rst) begin
            check("done_count", 32'(done_n), 1);
            if (mode == 0) check("done_cycle", 32'(done_c), N+2);
            check("bins_left", 32'(exp_q.size()), 0);
            check("reads_left", 32'(addr_q.size()), 0);
            check("busy_end", 32'(busy), 0);
        end
    endtask

    task automatic load(input logic [15:0] base0, input logic [15:0] base1, input bit zero0);
        for (int a = 0; a < N; a++) begin
            mem0[a] = zero0 ? 16'h0000 : base0 + 16'(a) + {8'(a), 8'h00} * ((base0[15:8] != 0) ? 16'd1 : 16'd0);
            mem1[a] = base1 + 16'(a) + {8'(a), 8'h00} * ((base1[15:8] != 0) ? 16'd1 : 16'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bank_sel  = 1'b0;
        out_ready = 1'b0;
        load(16'h0000, 16'h00A0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_en", 32'({ram0_en, ram1_en}), 0);
        check("reset_addr", 32'(ram_addr), 0);

        // RAM0 = address, full throughput
        run_readout(1'b0, 0, 1'b0, 1'b0, 1'b0);
        // RAM1 = 0xA0+addr, RAM0 zeroed, bank_sel flipped mid-readout
        load(16'h0000, 16'h00A0, 1'b1);
        run_readout(1'b1, 0, 1'b0, 1'b0, 1'b1);
        // Backpressure 1,0,0,1 with distinct I and Q
        load(16'h5000, 16'h00A0, 1'b0);
        run_readout(1'b0, 1, 1'b0, 1'b0, 1'b0);
        // Re-start pulses while busy and in the done cycle
        load(16'h0000, 16'hC030, 1'b0);
        run_readout(1'b1, 0, 1'b1, 1'b0, 1'b0);
        // Reset with bin 4 on the output, then a clean readout from index 0
        load(16'h0000, 16'h00A0, 1'b0);
        run_readout(1'b0, 0, 1'b0, 1'b1, 1'b0);
        run_readout(1'b0, 0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
